cascade_counter: RTL



---
 rtl/cascade_counter_pkg.sv | 22 ++
 rtl/counter_digit.sv | 56 +++++
 rtl/cascade_counter.sv | 81 ++++++++
 3 files changed

// File: rtl/cascade_counter_pkg.sv
// Shared types and helpers for the cascade_counter digit chain.
// Optional build macro: CASCADE_COUNTER_SAT_EN (saturating instead of wrapping).
package cascade_counter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } digit_op_t;

    // Out-of-range load digits are pulled down to the largest legal digit.
    function automatic int unsigned clamp_digit(input int unsigned d, input int unsigned val);
        return (d >= val) ? (val - 1) : d;
    endfunction

    function automatic int unsigned digit_max(input int unsigned val);
        return val - 1;
    endfunction

endpackage

// File: rtl/counter_digit.sv
// One radix-VAL up/down digit with synchronous clear and clamped load.
module counter_digit
    import cascade_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int VAL   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             up,
    input  logic             dn,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] DIG_MAX = WIDTH'(digit_max(VAL));

    digit_op_t        op;
    logic [WIDTH-1:0] ld_clamped;

    assign ld_clamped = WIDTH'(clamp_digit(32'(ld_val), VAL));
    assign at_max     = (q == DIG_MAX);
    assign at_min     = (q == '0);

    // Clear beats load beats counting; simultaneous up and down cancel.
    always_comb begin
        op = OP_HOLD;
        if (clr)
            op = OP_CLR;
        else if (ld)
            op = OP_LOAD;
        else if (up && !dn)
            op = OP_UP;
        else if (dn && !up)
            op = OP_DOWN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (op)
                OP_CLR:  q <= '0;
                OP_LOAD: q <= ld_clamped;
                OP_UP:   q <= at_max ? '0 : q + WIDTH'(1);
                OP_DOWN: q <= at_min ? DIG_MAX : q - WIDTH'(1);
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit radix-VAL up/down loadable counter with wrap/underflow flags.
// Define CASCADE_COUNTER_SAT_EN to make the counter saturate at its limits.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int VAL   = 10,
    parameter int NDIG  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [NDIG*WIDTH-1:0] load_val,
    output logic [NDIG*WIDTH-1:0] v,
    output logic                  r,
    output logic                  u
);

    localparam int TOTAL_W = NDIG * WIDTH;

    logic [NDIG:0]   carry;
    logic [NDIG:0]   borrow;
    logic [NDIG-1:0] at_max;
    logic [NDIG-1:0] at_min;
    logic            count_up;
    logic            count_dn;
    logic            all_max;
    logic            all_min;
    logic            step_up;
    logic            step_dn;

    assign count_up = en & ~load & inc & ~dec;
    assign count_dn = en & ~load & dec & ~inc;
    assign all_max  = carry[NDIG];
    assign all_min  = borrow[NDIG];

    assign r = ~rst & count_up & all_max;
    assign u = ~rst & count_dn & all_min;

`ifdef CASCADE_COUNTER_SAT_EN
    // A request that would cross the limit is dropped so every digit holds.
    assign step_up = count_up & ~all_max;
    assign step_dn = count_dn & ~all_min;
`else
    assign step_up = count_up;
    assign step_dn = count_dn;
`endif

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Digit i steps only when every lower digit sits at its limit.
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        assign carry[i+1]  = carry[i] & at_max[i];
        assign borrow[i+1] = borrow[i] & at_min[i];

        counter_digit #(
            .WIDTH (WIDTH),
            .VAL   (VAL)
        ) u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (~en),
            .ld     (load),
            .ld_val (load_val[i*WIDTH +: WIDTH]),
            .up     (step_up & carry[i]),
            .dn     (step_dn & borrow[i]),
            .q      (v[i*WIDTH +: WIDTH]),
            .at_max (at_max[i]),
            .at_min (at_min[i])
        );
    end

    if (TOTAL_W < 1) begin : g_bad_width
        $error("cascade_counter: NDIG*WIDTH must be positive");
    end

endmodule
